// File: rtl/koa_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : koa_seq_mult
//  Purpose  : Sequential single-level Karatsuba significand multiplier.
//             One shared (L+1)x(L+1) multiplier is used over three cycles to
//             form Q_left (high halves), Q_right (low halves) and Q_middle
//             ((A_hi+A_lo)*(B_hi+B_lo)). A fourth cycle combines them into
//             the exact 2*SW-bit product.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             valid_i/ready_o   - operand handshake (ready_o high in IDLE)
//             Data_A_i/Data_B_i - unsigned SW-bit operands
//             valid_o/ready_i   - product handshake (valid_o held in DONE)
//             busy_o            - high in every state except IDLE
//             sgf_result_o      - registered 2*SW-bit product
//  Options  : KOA_SEQ_ZERO_SKIP_EN - when defined, a zero operand at
//             acceptance goes straight to DONE with a zero result.
//  Revision : 1.0 - initial release
// ============================================================================
module koa_seq_mult #(
  parameter int SW = 54
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            busy_o,
  output logic [2*SW-1:0] sgf_result_o
);

  localparam int H  = SW / 2;   // high half width (floor)
  localparam int L  = SW - H;   // low half width (ceiling)
  localparam int M  = L + 1;    // shared multiplier operand width
  localparam int RW = 2 * SW;   // result width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_L = 3'd1,
    S_MUL_R = 3'd2,
    S_MUL_M = 3'd3,
    S_COMB  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [SW-1:0]  a_q, b_q;
  logic [2*H-1:0] ql_q;
  logic [2*L-1:0] qr_q;
  logic [2*M-1:0] qm_q;
  logic [RW-1:0]  result_q, result_d;
  logic           valid_q;

  logic           w_accept;
  logic           w_zero_skip;
  logic [H-1:0]   w_a_hi, w_b_hi;
  logic [L-1:0]   w_a_lo, w_b_lo;
  logic [M-1:0]   w_sa, w_sb;
  logic [M-1:0]   w_mul_a, w_mul_b;
  logic [2*M-1:0] w_mul_p;
  logic [RW-1:0]  w_ql_ext, w_qr_ext, w_qm_ext, w_mid;

  assign ready_o      = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign valid_o      = valid_q;
  assign sgf_result_o = result_q;
  assign w_accept     = valid_i && ready_o;

`ifdef KOA_SEQ_ZERO_SKIP_EN
  assign w_zero_skip = (Data_A_i == '0) || (Data_B_i == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  // Operand halves; the low half takes the extra bit when SW is odd.
  assign w_a_hi = a_q[SW-1:L];
  assign w_b_hi = b_q[SW-1:L];
  assign w_a_lo = a_q[L-1:0];
  assign w_b_lo = b_q[L-1:0];

  // Half sums feed the shared multiplier directly during MUL_M.
  assign w_sa = M'(w_a_lo) + M'(w_a_hi);
  assign w_sb = M'(w_b_lo) + M'(w_b_hi);

  // Shared multiplier operand select.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (state_q)
      S_MUL_L: begin
        w_mul_a = M'(w_a_hi);
        w_mul_b = M'(w_b_hi);
      end
      S_MUL_R: begin
        w_mul_a = M'(w_a_lo);
        w_mul_b = M'(w_b_lo);
      end
      S_MUL_M: begin
        w_mul_a = w_sa;
        w_mul_b = w_sb;
      end
      default: ;
    endcase
  end

  assign w_mul_p = {{M{1'b0}}, w_mul_a} * {{M{1'b0}}, w_mul_b};

  // Combine. The exact sum fits in 2*SW bits, so evaluating it modulo
  // 2^(2*SW) gives the same result as a wider datapath truncated
  // afterwards. Q_middle >= Q_left + Q_right always, so the difference
  // never wraps in the exact arithmetic.
  assign w_ql_ext = RW'(ql_q);
  assign w_qr_ext = RW'(qr_q);
  assign w_qm_ext = RW'(qm_q);
  assign w_mid    = w_qm_ext - w_ql_ext - w_qr_ext;
  assign result_d = (w_ql_ext << (2 * L)) + (w_mid << L) + w_qr_ext;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = w_zero_skip ? S_DONE : S_MUL_L;
      S_MUL_L: state_d = S_MUL_R;
      S_MUL_R: state_d = S_MUL_M;
      S_MUL_M: state_d = S_COMB;
      S_COMB:  state_d = S_DONE;
      S_DONE:  if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      ql_q     <= '0;
      qr_q     <= '0;
      qm_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            a_q <= Data_A_i;
            b_q <= Data_B_i;
            if (w_zero_skip) begin
              result_q <= '0;
              valid_q  <= 1'b1;
            end
          end
        end
        S_MUL_L: ql_q <= w_mul_p[2*H-1:0];
        S_MUL_R: qr_q <= w_mul_p[2*L-1:0];
        S_MUL_M: qm_q <= w_mul_p;
        S_COMB: begin
          result_q <= result_d;
          valid_q  <= 1'b1;
        end
        S_DONE: if (ready_i) valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_koa_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_koa_seq_mult
//  Purpose  : Scoreboard bench for koa_seq_mult (SW=54 main instance) plus
//             directed checks on SW=53 and SW=24 instances.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_koa_seq_mult;

  localparam int SW = 54;

`ifdef KOA_SEQ_ZERO_SKIP_EN
  // Zero operand: DONE is entered on the accepting edge itself.
  localparam int ZLAT  = 0;
  localparam int ZBUSY = 1;
`else
  localparam int ZLAT  = 4;
  localparam int ZBUSY = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic            valid_i = 1'b0;
  logic            ready_i = 1'b1;
  logic [SW-1:0]   Data_A_i = '0;
  logic [SW-1:0]   Data_B_i = '0;
  logic            ready_o, valid_o, busy_o;
  logic [2*SW-1:0] sgf_result_o;

  logic          c53_valid_i = 1'b0;
  logic          c53_ready_i = 1'b1;
  logic [52:0]   c53_a = '0, c53_b = '0;
  logic          c53_ready_o, c53_valid_o, c53_busy_o;
  logic [105:0]  c53_res;

  logic          c24_valid_i = 1'b0;
  logic          c24_ready_i = 1'b1;
  logic [23:0]   c24_a = '0, c24_b = '0;
  logic          c24_ready_o, c24_valid_o, c24_busy_o;
  logic [47:0]   c24_res;

  always #5 clk = ~clk;

  koa_seq_mult #(.SW(SW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .Data_A_i(Data_A_i), .Data_B_i(Data_B_i), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o), .sgf_result_o(sgf_result_o)
  );

  koa_seq_mult #(.SW(53)) u53 (
    .clk(clk), .rst(rst), .valid_i(c53_valid_i), .ready_o(c53_ready_o),
    .Data_A_i(c53_a), .Data_B_i(c53_b), .valid_o(c53_valid_o),
    .ready_i(c53_ready_i), .busy_o(c53_busy_o), .sgf_result_o(c53_res)
  );

  koa_seq_mult #(.SW(24)) u24 (
    .clk(clk), .rst(rst), .valid_i(c24_valid_i), .ready_o(c24_ready_o),
    .Data_A_i(c24_a), .Data_B_i(c24_b), .valid_o(c24_valid_o),
    .ready_i(c24_ready_i), .busy_o(c24_busy_o), .sgf_result_o(c24_res)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*SW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expected product per output handshake.
  task automatic monitor();
    logic [2*SW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_product: actual=%h required=none", sgf_result_o);
        end else begin
          e = exp_q.pop_front();
          chk("product", sgf_result_o, e);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input logic [2*SW-1:0] e, input bit push);
    int k;
    k = 0;
    while (!ready_o && k < 50) begin
      step();
      k++;
    end
    if (!ready_o) chk("ready_timeout", ready_o, 1);
    Data_A_i = a;
    Data_B_i = b;
    valid_i  = 1'b1;
    if (push) exp_q.push_back(e);
    step();
    valid_i = 1'b0;
  endtask

  // Issue one operation with ready_i=1 and watch a fixed 12-cycle window.
  task automatic run_op(input logic [SW-1:0] a, input logic [SW-1:0] b,
                        input logic [2*SW-1:0] e, input int exp_lat,
                        input int exp_busy, input bit chk_busy);
    int lat;
    int nb;
    accept(a, b, e, 1'b1);
    lat = -1;
    nb  = 0;
    for (int j = 0; j < 12; j++) begin
      if (busy_o) nb++;
      if (valid_o && lat < 0) lat = j;
      step();
    end
    chk("latency", lat, exp_lat);
    if (chk_busy) chk("busy_cycles", nb, exp_busy);
  endtask

  task automatic run53(input logic [52:0] a, input logic [52:0] b, input logic [105:0] e);
    int k;
    c53_a = a;
    c53_b = b;
    c53_valid_i = 1'b1;
    step();
    c53_valid_i = 1'b0;
    k = 0;
    while (!c53_valid_o && k < 20) begin
      step();
      k++;
    end
    chk("sw53_latency", k, 4);
    chk("sw53_product", c53_res, e);
    step();
  endtask

  task automatic run24(input logic [23:0] a, input logic [23:0] b, input logic [47:0] e);
    int k;
    c24_a = a;
    c24_b = b;
    c24_valid_i = 1'b1;
    step();
    c24_valid_i = 1'b0;
    k = 0;
    while (!c24_valid_o && k < 20) begin
      step();
      k++;
    end
    chk("sw24_latency", k, 4);
    chk("sw24_product", c24_res, e);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2*SW-1:0] e;
    logic [2*SW-1:0] ra, rb;
    logic [105:0]    e53;
    int k;

    fork
      monitor();
    join_none

    // Reset state.
    rst = 1'b1;
    step();
    step();
    chk("rst_ready_o", ready_o, 1);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_busy_o", busy_o, 0);
    chk("rst_result", sgf_result_o, 0);
    rst = 1'b0;
    step();

    // Basic latency and busy duration.
    run_op(54'd3, 54'd5, 108'd15, 4, 5, 1'b1);

    // All-ones operands: 2^108 - 2^55 + 1.
    e = 108'd0 - (108'd1 << 55) + 108'd1;
    run_op({SW{1'b1}}, {SW{1'b1}}, e, 4, 5, 1'b1);

    // Directed: high-half-only and mixed operands.
    run_op(54'd1 << 53, 54'd1 << 53, 108'd1 << 106, 4, 5, 1'b0);
    run_op(54'h12345, 54'h6789, 108'd1976345325, 4, 5, 1'b0);

    // Random pairs against the plain product.
    for (int i = 0; i < 1000; i++) begin
      ra = 108'(54'({$urandom(), $urandom()}));
      rb = 108'(54'({$urandom(), $urandom()}));
      if (ra == 0) ra = 108'd1;
      if (rb == 0) rb = 108'd1;
      run_op(ra[SW-1:0], rb[SW-1:0], ra * rb, 4, 5, 1'b0);
    end

    // Backpressure, with valid_i asserted while busy.
    ready_i = 1'b0;
    e = 108'd1976345325;
    accept(54'h12345, 54'h6789, e, 1'b1);
    valid_i  = 1'b1;
    Data_A_i = {SW{1'b1}};
    Data_B_i = {SW{1'b1}};
    step();
    step();
    valid_i = 1'b0;
    k = 0;
    while (!valid_o && k < 20) begin
      step();
      k++;
    end
    chk("bp_valid_rise", valid_o, 1);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("bp_valid_held", valid_o, 1);
      chk("bp_result_held", sgf_result_o, e);
    end
    ready_i = 1'b1;
    step();
    chk("bp_valid_drop", valid_o, 0);
    chk("bp_ready_back", ready_o, 1);
    chk("bp_result_kept", sgf_result_o, e);

    // Reset while in MUL_M discards the operation.
    accept(54'h1111, 54'h2222, 108'd0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_valid_o", valid_o, 0);
    chk("mid_rst_busy_o", busy_o, 0);
    chk("mid_rst_ready_o", ready_o, 1);
    chk("mid_rst_result", sgf_result_o, 0);
    rst = 1'b0;
    step();
    run_op(54'd7, 54'd9, 108'd63, 4, 5, 1'b1);

    // Zero operand.
    run_op(54'd0, 54'h123, 108'd0, ZLAT, ZBUSY, 1'b1);

    // Odd split, SW=53.
    e53 = 106'd0 - (106'd1 << 54) + 106'd1;
    run53({53{1'b1}}, {53{1'b1}}, e53);
    run53(53'd3, 53'd5, 106'd15);
    run53(53'd1 << 52, 53'd1 << 52, 106'd1 << 104);

    // Single precision, SW=24.
    run24(24'hFFFFFF, 24'h800000, 48'h7FFFFF800000);
    run24(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    run24(24'h800000, 24'h800000, 48'h400000000000);

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
